// File: rtl/eespfal_pkg.sv
// rtl/eespfal_pkg.sv - shared types, defaults and helpers for the EESPFAL phase sequencer
package eespfal_pkg;

  localparam int BIT_SIZE_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  // Null spacer level for all dual-rail data lines between evaluations.
  localparam logic SPACER = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIS  = 3'd1,
    ST_EVAL = 3'd2,
    ST_SAMP = 3'd3,
    ST_REC  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  function automatic int unsigned dur_clamp(input int unsigned dur);
    return (dur == 0) ? 1 : dur;
  endfunction

endpackage

// File: rtl/eespfal_phase_sequencer_if.sv
// rtl/eespfal_phase_sequencer_if.sv - request/response handshake bundle of the phase sequencer
interface eespfal_phase_sequencer_if
  import eespfal_pkg::*;
#(
  parameter int BIT_SIZE = BIT_SIZE_DEF,
  parameter int CNT_W    = CNT_W_DEF
);
  logic                req_valid;
  logic                req_ready;
  logic [BIT_SIZE-1:0] req_x;
  logic [BIT_SIZE-1:0] req_k;
  logic [CNT_W-1:0]    cfg_dis_cyc;
  logic [CNT_W-1:0]    cfg_eval_cyc;
  logic [CNT_W-1:0]    cfg_rec_cyc;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [BIT_SIZE-1:0] rsp_s;
  logic                rsp_err;
  logic                busy;

  modport master (
    output req_valid, req_x, req_k, cfg_dis_cyc, cfg_eval_cyc, cfg_rec_cyc, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_x, req_k, cfg_dis_cyc, cfg_eval_cyc, cfg_rec_cyc, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_err, busy
  );
endinterface

// File: rtl/eespfal_phase_timer.sv
// rtl/eespfal_phase_timer.sv - loadable down-counter that flags the last cycle of a phase
module eespfal_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer never wraps back to a long count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/eespfal_phase_sequencer.sv
// rtl/eespfal_phase_sequencer.sv - discharge/evaluate/sample/recover sequencer for one EESPFAL lane
// Define EESPFAL_SYNC_EN to add a 2-flop synchronizer on lane_s/lane_s_bar and a 3-cycle sample phase.
module eespfal_phase_sequencer
  import eespfal_pkg::*;
#(
  parameter int BIT_SIZE = BIT_SIZE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  eespfal_phase_sequencer_if.slave bus,
  output logic [BIT_SIZE-1:0]      lane_clk,
  output logic [BIT_SIZE-1:0]      lane_dis,
  output logic                     lane_dis_phase,
  output logic [BIT_SIZE-1:0]      lane_x,
  output logic [BIT_SIZE-1:0]      lane_x_bar,
  output logic [BIT_SIZE-1:0]      lane_k,
  output logic [BIT_SIZE-1:0]      lane_k_bar,
  input  logic [BIT_SIZE-1:0]      lane_s,
  input  logic [BIT_SIZE-1:0]      lane_s_bar
);
`ifdef EESPFAL_SYNC_EN
  localparam int SAMP_CYC = 3;
`else
  localparam int SAMP_CYC = 1;
`endif

  function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] dur);
    return CNT_W'(dur_clamp(32'(dur)) - 1);
  endfunction

  state_t              state_q, state_d;
  logic [BIT_SIZE-1:0] x_q, x_d, k_q, k_d;
  logic [CNT_W-1:0]    eval_m1_q, eval_m1_d, rec_m1_q, rec_m1_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BIT_SIZE-1:0] rsp_s_q, rsp_s_d;
  logic                rsp_err_q, rsp_err_d;
  logic [BIT_SIZE-1:0] lane_clk_q, lane_clk_d, lane_dis_q, lane_dis_d;
  logic                lane_dis_phase_q, lane_dis_phase_d;
  logic [BIT_SIZE-1:0] lane_x_q, lane_x_d, lane_x_bar_q, lane_x_bar_d;
  logic [BIT_SIZE-1:0] lane_k_q, lane_k_d, lane_k_bar_q, lane_k_bar_d;
  logic                tmr_load, tmr_done;
  logic [CNT_W-1:0]    tmr_val;
  logic [BIT_SIZE-1:0] s_cap, s_bar_cap;

`ifdef EESPFAL_SYNC_EN
  logic [BIT_SIZE-1:0] s_sync1_q, s_sync2_q, s_bar_sync1_q, s_bar_sync2_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_sync1_q     <= '0;
      s_sync2_q     <= '0;
      s_bar_sync1_q <= '0;
      s_bar_sync2_q <= '0;
    end else begin
      s_sync1_q     <= lane_s;
      s_sync2_q     <= s_sync1_q;
      s_bar_sync1_q <= lane_s_bar;
      s_bar_sync2_q <= s_bar_sync1_q;
    end
  end

  assign s_cap     = s_sync2_q;
  assign s_bar_cap = s_bar_sync2_q;
`else
  assign s_cap     = lane_s;
  assign s_bar_cap = lane_s_bar;
`endif

  eespfal_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    k_d       = k_q;
    eval_m1_d = eval_m1_q;
    rec_m1_d  = rec_m1_q;
    rsp_s_d   = rsp_s_q;
    rsp_err_d = rsp_err_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d   = ST_DIS;
          x_d       = bus.req_x;
          k_d       = bus.req_k;
          eval_m1_d = dur_m1(bus.cfg_eval_cyc);
          rec_m1_d  = dur_m1(bus.cfg_rec_cyc);
          tmr_load  = 1'b1;
          tmr_val   = dur_m1(bus.cfg_dis_cyc);
        end
      end
      ST_DIS: begin
        if (tmr_done) begin
          state_d  = ST_EVAL;
          tmr_load = 1'b1;
          tmr_val  = eval_m1_q;
        end
      end
      ST_EVAL: begin
        if (tmr_done) begin
          state_d  = ST_SAMP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SAMP_CYC - 1);
        end
      end
      ST_SAMP: begin
        if (tmr_done) begin
          state_d   = ST_REC;
          tmr_load  = 1'b1;
          tmr_val   = rec_m1_q;
          rsp_s_d   = s_cap;
          rsp_err_d = |(s_cap ~^ s_bar_cap);
        end
      end
      ST_REC: begin
        if (tmr_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane drive is decoded from the next state so the registered outputs line up with the state register.
  always_comb begin
    rsp_valid_d      = (state_d == ST_RESP);
    lane_clk_d       = '0;
    lane_dis_d       = '0;
    lane_dis_phase_d = 1'b0;
    lane_x_d         = {BIT_SIZE{SPACER}};
    lane_x_bar_d     = {BIT_SIZE{SPACER}};
    lane_k_d         = {BIT_SIZE{SPACER}};
    lane_k_bar_d     = {BIT_SIZE{SPACER}};
    case (state_d)
      ST_DIS: begin
        lane_dis_d       = '1;
        lane_dis_phase_d = 1'b1;
      end
      ST_EVAL, ST_SAMP: begin
        lane_clk_d   = '1;
        lane_x_d     = x_d;
        lane_x_bar_d = ~x_d;
        lane_k_d     = k_d;
        lane_k_bar_d = ~k_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q          <= ST_IDLE;
      x_q              <= '0;
      k_q              <= '0;
      eval_m1_q        <= '0;
      rec_m1_q         <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_s_q          <= '0;
      rsp_err_q        <= 1'b0;
      lane_clk_q       <= '0;
      lane_dis_q       <= '0;
      lane_dis_phase_q <= 1'b0;
      lane_x_q         <= '0;
      lane_x_bar_q     <= '0;
      lane_k_q         <= '0;
      lane_k_bar_q     <= '0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      k_q              <= k_d;
      eval_m1_q        <= eval_m1_d;
      rec_m1_q         <= rec_m1_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_s_q          <= rsp_s_d;
      rsp_err_q        <= rsp_err_d;
      lane_clk_q       <= lane_clk_d;
      lane_dis_q       <= lane_dis_d;
      lane_dis_phase_q <= lane_dis_phase_d;
      lane_x_q         <= lane_x_d;
      lane_x_bar_q     <= lane_x_bar_d;
      lane_k_q         <= lane_k_d;
      lane_k_bar_q     <= lane_k_bar_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_s      = rsp_s_q;
  assign bus.rsp_err    = rsp_err_q;
  assign lane_clk       = lane_clk_q;
  assign lane_dis       = lane_dis_q;
  assign lane_dis_phase = lane_dis_phase_q;
  assign lane_x         = lane_x_q;
  assign lane_x_bar     = lane_x_bar_q;
  assign lane_k         = lane_k_q;
  assign lane_k_bar     = lane_k_bar_q;
endmodule

// File: tb/tb_eespfal_phase_sequencer.sv
// tb/tb_eespfal_phase_sequencer.sv - directed self-checking bench for eespfal_phase_sequencer
module tb_eespfal_phase_sequencer;
`ifdef EESPFAL_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] lane_clk, lane_dis, lane_x, lane_x_bar, lane_k, lane_k_bar;
  logic       lane_dis_phase;
  logic [3:0] lane_s, lane_s_bar;
  logic [3:0] model_s, model_s_bar;
  logic [3:0] xb_seen, kb_seen;
  int         n_cmp, n_err;
  int         lat, clk_hi, seen;

  eespfal_phase_sequencer_if #(.BIT_SIZE(4), .CNT_W(8)) bus ();

  eespfal_phase_sequencer #(.BIT_SIZE(4), .CNT_W(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .bus            (bus),
    .lane_clk       (lane_clk),
    .lane_dis       (lane_dis),
    .lane_dis_phase (lane_dis_phase),
    .lane_x         (lane_x),
    .lane_x_bar     (lane_x_bar),
    .lane_k         (lane_k),
    .lane_k_bar     (lane_k_bar),
    .lane_s         (lane_s),
    .lane_s_bar     (lane_s_bar)
  );

  // Lane model: results only present while the power clock is up.
  assign lane_s     = (lane_clk == 4'hF) ? model_s : 4'h0;
  assign lane_s_bar = (lane_clk == 4'hF) ? model_s_bar : 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] x, input logic [3:0] k,
                          input logic [7:0] d, input logic [7:0] e, input logic [7:0] r);
    bus.req_x = x;
    bus.req_k = k;
    bus.cfg_dis_cyc  = d;
    bus.cfg_eval_cyc = e;
    bus.cfg_rec_cyc  = r;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l, output int hi);
    l = 0;
    hi = 0;
    while (!bus.rsp_valid && l < 600) begin
      if (lane_clk == 4'hF) begin
        hi++;
        xb_seen = lane_x_bar;
        kb_seen = lane_k_bar;
      end
      tick();
      l++;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("hs_req_ready", 32'(bus.req_ready), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_x = 4'h0;
    bus.req_k = 4'h0;
    bus.cfg_dis_cyc = 8'h0;
    bus.cfg_eval_cyc = 8'h0;
    bus.cfg_rec_cyc = 8'h0;
    model_s = 4'h0;
    model_s_bar = 4'h0;
    xb_seen = 4'h0;
    kb_seen = 4'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_lanes", {lane_clk, lane_dis, lane_x, lane_x_bar, lane_k, lane_k_bar, 7'(lane_dis_phase)}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Nominal operation
    model_s = 4'h9; model_s_bar = 4'h6;
    start_op(4'hA, 4'h3, 8'd2, 8'd3, 8'd2);
    chk("nom_busy", 32'(bus.busy), 1);
    chk("nom_dis", 32'(lane_dis), 32'hF);
    chk("nom_dis_phase", 32'(lane_dis_phase), 1);
    wait_rsp(lat, clk_hi);
    chk("nom_lat", lat, 8 + SX);
    chk("nom_clk_hi", clk_hi, 4 + SX);
    chk("nom_x_bar", 32'(xb_seen), 32'h5);
    chk("nom_k_bar", 32'(kb_seen), 32'hC);
    chk("nom_rsp_s", 32'(bus.rsp_s), 32'h9);
    chk("nom_rsp_err", 32'(bus.rsp_err), 0);
    handshake();

    // Dual-rail integrity violation
    model_s = 4'h9; model_s_bar = 4'hF;
    start_op(4'hA, 4'h3, 8'd2, 8'd3, 8'd2);
    wait_rsp(lat, clk_hi);
    chk("int_lat", lat, 8 + SX);
    chk("int_rsp_s", 32'(bus.rsp_s), 32'h9);
    chk("int_rsp_err", 32'(bus.rsp_err), 1);
    handshake();

    // Zero config clamps every phase to one cycle
    model_s = 4'h3; model_s_bar = 4'hC;
    start_op(4'h1, 4'h2, 8'd0, 8'd0, 8'd0);
    wait_rsp(lat, clk_hi);
    chk("zero_lat", lat, 4 + SX);
    chk("zero_clk_hi", clk_hi, 2 + SX);
    chk("zero_rsp_s", 32'(bus.rsp_s), 32'h3);
    chk("zero_rsp_err", 32'(bus.rsp_err), 0);
    handshake();

    // Backpressure with a pending second request
    model_s = 4'h9; model_s_bar = 4'h6;
    start_op(4'hA, 4'h3, 8'd2, 8'd3, 8'd2);
    wait_rsp(lat, clk_hi);
    chk("bp_lat", lat, 8 + SX);
    bus.req_x = 4'h5; bus.req_k = 4'hC;
    bus.cfg_dis_cyc = 8'd1; bus.cfg_eval_cyc = 8'd1; bus.cfg_rec_cyc = 8'd1;
    bus.req_valid = 1'b1;
    model_s = 4'h6; model_s_bar = 4'h9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_s", {bus.rsp_s, 3'(bus.rsp_err)}, {4'h9, 3'd0});
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("bp_hs_busy", 32'(bus.busy), 0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_second_accept", 32'(bus.busy), 1);
    wait_rsp(lat, clk_hi);
    chk("bp2_lat", lat, 4 + SX);
    chk("bp2_x_bar", 32'(xb_seen), 32'hA);
    chk("bp2_rsp_s", 32'(bus.rsp_s), 32'h6);
    chk("bp2_rsp_err", 32'(bus.rsp_err), 0);
    handshake();

    // Maximum evaluate duration
    model_s = 4'h9; model_s_bar = 4'h6;
    start_op(4'hA, 4'h3, 8'd1, 8'hFF, 8'd1);
    wait_rsp(lat, clk_hi);
    chk("max_clk_hi", clk_hi, 256 + SX);
    chk("max_lat", lat, 258 + SX);
    chk("max_rsp_s", 32'(bus.rsp_s), 32'h9);
    handshake();

    // Reset in the second evaluate cycle
    start_op(4'hA, 4'h3, 8'd2, 8'd3, 8'd2);
    tick();
    tick();
    tick();
    chk("mid_in_eval", {lane_clk, lane_x_bar}, {4'hF, 4'h5});
    rst = 1'b1;
    #1;
    chk("mid_lanes", {lane_clk, lane_dis, lane_x, lane_x_bar, lane_k, lane_k_bar, 7'(lane_dis_phase)}, 0);
    chk("mid_req_ready", 32'(bus.req_ready), 1);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rsp_s", 32'(bus.rsp_s), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid || bus.busy) seen++;
    end
    chk("mid_no_rsp", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
